// File: rtl/edge_toggle_tx.sv
// Edge-signalling transmitter: turns local event strobes into spaced edges (toggle)
// or spaced pulses on signalOut, queueing bursts in a saturating pending counter.
module edge_toggle_tx #(
   parameter int HOLD_CYCLES = 4,
   parameter int PEND_WIDTH  = 4,
   parameter bit PULSE_MODE  = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  eventIn,
   input  logic                  enable,
   input  logic                  clearOverflow,
   output logic                  signalOut,
   output logic                  busy,
   output logic [PEND_WIDTH-1:0] pending,
   output logic                  overflow,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

   localparam logic [7:0]            RELOAD   = 8'(HOLD_CYCLES - 1);
   localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
   localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

   state_t                state, state_nx;
   logic [7:0]            timer, timer_nx;
   logic                  sig_nx;
   logic [PEND_WIDTH-1:0] pend_nx;
   logic                  ovf_nx;
   logic                  start_ok, start, take_q, direct, inc, drop;

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      sig_nx   = signalOut;
      start    = 1'b0;
      start_ok = enable && ((pending != '0) || eventIn);

      case (state)
         IDLE: if (start_ok) start = 1'b1;
         HOLD, LOW: begin
            if (timer == 8'd0) begin
               if (start_ok) start = 1'b1;
               else          state_nx = IDLE;
            end else begin
               timer_nx = timer - 8'd1;
            end
         end
         HIGH: begin
            if (timer == 8'd0) begin
               sig_nx   = 1'b0;
               timer_nx = RELOAD;
               state_nx = LOW;
            end else begin
               timer_nx = timer - 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (start) begin
         timer_nx = RELOAD;
         if (PULSE_MODE) begin
            sig_nx   = 1'b1;
            state_nx = HIGH;
         end else begin
            sig_nx   = ~signalOut;
            state_nx = HOLD;
         end
      end

      // A start with an empty queue can only be caused by this cycle's event.
      take_q = start && (pending != '0);
      direct = start && (pending == '0);
      inc    = eventIn && !direct;
      drop   = inc && !take_q && (pending == PEND_MAX);

      pend_nx = pending;
      if (inc && !take_q && !drop) pend_nx = pending + PEND_ONE;
      else if (take_q && !inc)     pend_nx = pending - PEND_ONE;

      ovf_nx = overflow;
      if (drop)               ovf_nx = 1'b1;
      else if (clearOverflow) ovf_nx = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= 8'd0;
         signalOut <= 1'b0;
         pending   <= '0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         signalOut <= sig_nx;
         pending   <= pend_nx;
         overflow  <= ovf_nx;
      end
   end

   assign busy      = (state != IDLE) || (pending != '0);
   assign state_dbg = state;

endmodule

// File: tb/tb_edge_toggle_tx.sv
// Directed bench for edge_toggle_tx: toggle, pulse and small-queue instances
// plus 3-flop receiver models counting edges on the line outputs.
module tb_edge_toggle_tx;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // toggle mode, HOLD=4, PEND_WIDTH=4
   logic ev_t = 0, en_t = 0, clr_t = 0;
   logic sig_t, busy_t, ovf_t;
   logic [3:0] pend_t;
   logic [1:0] st_t;
   // pulse mode, HOLD=3
   logic ev_p = 0, en_p = 0, clr_p = 0;
   logic sig_p, busy_p, ovf_p;
   logic [3:0] pend_p;
   logic [1:0] st_p;
   // toggle mode, small queue PEND_WIDTH=2
   logic ev_o = 0, en_o = 0, clr_o = 0;
   logic sig_o, busy_o, ovf_o;
   logic [1:0] pend_o;
   logic [1:0] st_o;

   edge_toggle_tx #(.HOLD_CYCLES(4), .PEND_WIDTH(4), .PULSE_MODE(1'b0)) dut_t (
      .clk(clk), .reset(reset), .eventIn(ev_t), .enable(en_t), .clearOverflow(clr_t),
      .signalOut(sig_t), .busy(busy_t), .pending(pend_t), .overflow(ovf_t), .state_dbg(st_t));
   edge_toggle_tx #(.HOLD_CYCLES(3), .PEND_WIDTH(4), .PULSE_MODE(1'b1)) dut_p (
      .clk(clk), .reset(reset), .eventIn(ev_p), .enable(en_p), .clearOverflow(clr_p),
      .signalOut(sig_p), .busy(busy_p), .pending(pend_p), .overflow(ovf_p), .state_dbg(st_p));
   edge_toggle_tx #(.HOLD_CYCLES(4), .PEND_WIDTH(2), .PULSE_MODE(1'b0)) dut_o (
      .clk(clk), .reset(reset), .eventIn(ev_o), .enable(en_o), .clearOverflow(clr_o),
      .signalOut(sig_o), .busy(busy_o), .pending(pend_o), .overflow(ovf_o), .state_dbg(st_o));

   // far-end receivers: 3-flop synchroniser, flag on every edge
   logic [2:0] sync_t = 3'b000, sync_p = 3'b000;
   int flags_t = 0, flags_p = 0;
   always @(posedge clk) begin
      sync_t <= {sync_t[1:0], sig_t};
      sync_p <= {sync_p[1:0], sig_p};
      if (sync_t[2] ^ sync_t[1]) flags_t <= flags_t + 1;
      if (sync_p[2] ^ sync_p[1]) flags_p <= flags_p + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int   n;
      int   fb;
      logic e;

      // reset
      tick(); tick();
      chk("rst_sig_t", 32'(sig_t), 32'd0);
      chk("rst_busy_t", 32'(busy_t), 32'd0);
      chk("rst_pend_t", 32'(pend_t), 32'd0);
      chk("rst_ovf_t", 32'(ovf_t), 32'd0);
      chk("rst_sig_p", 32'(sig_p), 32'd0);
      reset = 1'b0;
      en_t = 1'b1;
      en_p = 1'b1;
      tick(); tick();

      // single event: edge next cycle, busy for HOLD cycles
      fb = flags_t;
      ev_t = 1'b1;
      tick();
      ev_t = 1'b0;
      chk("single_sig", 32'(sig_t), 32'd1);
      chk("single_busy", 32'(busy_t), 32'd1);
      chk("single_pend", 32'(pend_t), 32'd0);
      tick(); tick(); tick();
      chk("single_busy_last", 32'(busy_t), 32'd1);
      tick();
      chk("single_busy_off", 32'(busy_t), 32'd0);
      chk("single_sig_hold", 32'(sig_t), 32'd1);
      for (int i = 0; i < 6; i++) tick();
      chk("single_rx", 32'(flags_t - fb), 32'd1);

      // burst of 5: edges at +1,+5,+9,+13,+17 from line level 1
      fb = flags_t;
      ev_t = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         tick();
         ev_t = (i <= 4);
         n = (i + 3) / 4;
         if (n > 5) n = 5;
         e = 1'b1 ^ n[0];
         chk("burst_sig", 32'(sig_t), 32'(e));
         if (i == 4 || i == 5) chk("burst_pend_peak", 32'(pend_t), 32'd3);
         if (i == 17) chk("burst_pend_empty", 32'(pend_t), 32'd0);
      end
      chk("burst_busy_off", 32'(busy_t), 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("burst_rx", 32'(flags_t - fb), 32'd5);

      // pulse mode, two events: high 3, low 3, high 3, low 3
      fb = flags_p;
      ev_p = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         ev_p = (i < 2);
         e = (i >= 1 && i <= 3) || (i >= 7 && i <= 9);
         chk("pulse_sig", 32'(sig_p), 32'(e));
         if (i == 2) chk("pulse_pend", 32'(pend_p), 32'd1);
         if (i == 12) chk("pulse_busy_on", 32'(busy_p), 32'd1);
         if (i == 13) chk("pulse_busy_off", 32'(busy_p), 32'd0);
      end
      for (int i = 0; i < 6; i++) tick();
      chk("pulse_rx", 32'(flags_p - fb), 32'd4);

      // overflow with transmission disabled
      ev_o = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 3) begin
            chk("ovf_pend_full", 32'(pend_o), 32'd3);
            chk("ovf_not_yet", 32'(ovf_o), 32'd0);
         end
         ev_o = (i < 5);
      end
      chk("ovf_pend_sat", 32'(pend_o), 32'd3);
      chk("ovf_set", 32'(ovf_o), 32'd1);
      chk("ovf_no_edge", 32'(sig_o), 32'd0);
      ev_o = 1'b1;
      clr_o = 1'b1;
      tick();
      ev_o = 1'b0;
      clr_o = 1'b0;
      chk("ovf_drop_beats_clear", 32'(ovf_o), 32'd1);
      clr_o = 1'b1;
      tick();
      clr_o = 1'b0;
      chk("ovf_cleared", 32'(ovf_o), 32'd0);
      chk("ovf_pend_kept", 32'(pend_o), 32'd3);
      en_o = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         n = (i + 3) / 4;
         if (n > 3) n = 3;
         e = n[0];
         chk("drain_sig", 32'(sig_o), 32'(e));
         if (i == 13) begin
            chk("drain_busy", 32'(busy_o), 32'd0);
            chk("drain_pend", 32'(pend_o), 32'd0);
         end
      end

      // enable dropped mid-HOLD with two queued events (line level 0 at start)
      ev_t = 1'b1;
      tick();
      chk("gate_edge", 32'(sig_t), 32'd1);
      en_t = 1'b0;
      tick();
      tick();
      ev_t = 1'b0;
      chk("gate_pend", 32'(pend_t), 32'd2);
      tick();
      chk("gate_state_hold", 32'(st_t), 32'd1);
      tick();
      chk("gate_state_idle", 32'(st_t), 32'd0);
      chk("gate_busy_q", 32'(busy_t), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("gate_no_edge", 32'(sig_t), 32'd1);
      chk("gate_pend_kept", 32'(pend_t), 32'd2);
      en_t = 1'b1;
      tick();
      chk("gate_resume_sig", 32'(sig_t), 32'd0);
      chk("gate_resume_pend", 32'(pend_t), 32'd1);
      for (int i = 0; i < 4; i++) tick();
      chk("gate_second_sig", 32'(sig_t), 32'd1);
      chk("gate_second_pend", 32'(pend_t), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("gate_idle_busy", 32'(busy_t), 32'd0);

      // async reset while a pulse is high
      ev_p = 1'b1;
      tick();
      tick();
      ev_p = 1'b0;
      chk("arst_pre_sig", 32'(sig_p), 32'd1);
      chk("arst_pre_pend", 32'(pend_p), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_sig", 32'(sig_p), 32'd0);
      chk("arst_pend", 32'(pend_p), 32'd0);
      chk("arst_busy", 32'(busy_p), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      chk("arst_hold_sig", 32'(sig_p), 32'd0);
      ev_p = 1'b1;
      tick();
      ev_p = 1'b0;
      chk("arst_resume_sig", 32'(sig_p), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
